// File: rtl/rename_active_list.sv
// In-order rename active list: commit frees old_preg, flush rolls back youngest-first
// restoring the rename map and freeing new_preg.
module rename_active_list #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned AREG_W = 5,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_arch_rd,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic [PREG_W-1:0] alloc_new_preg,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              done_valid,
    input  logic [IDX_W-1:0]  done_idx,
    input  logic              flush_valid,
    input  logic [IDX_W-1:0]  flush_idx,
    output logic              free_w_en,
    output logic [PREG_W-1:0] free_dat,
    output logic              map_restore_en,
    output logic [AREG_W-1:0] map_restore_arch,
    output logic [PREG_W-1:0] map_restore_preg,
    output logic              busy,
    output logic [IDX_W:0]    count
);

    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_ROLLBACK = 1'b1;

    logic [0:0]       state_q, state_nxt;
    logic [PTR_W-1:0] head_q, head_nxt, tail_q, tail_nxt, target_q, target_nxt;
    logic [PTR_W-1:0] cnt, flush_ptr;
    logic [IDX_W-1:0] head_idx, tail_idx, pop_idx, done_off, flush_off;
    logic             full, empty, alloc_fire, commit, done_occ, flush_occ, flush_acc;

    logic [DEPTH-1:0]  done_q;
    logic              has_dest_q [DEPTH];
    logic [AREG_W-1:0] arch_q     [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];
    logic [PREG_W-1:0] new_preg_q [DEPTH];

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign pop_idx   = tail_idx - IDX_W'(1);
    assign cnt       = tail_q - head_q;
    assign full      = (cnt == PTR_W'(DEPTH));
    assign empty     = (cnt == '0);

    // Slot occupancy: distance from head (mod DEPTH) must fall below the occupancy count.
    assign done_off  = done_idx - head_idx;
    assign flush_off = flush_idx - head_idx;
    assign done_occ  = ({1'b0, done_off} < cnt);
    assign flush_occ = ({1'b0, flush_off} < cnt);
    assign flush_ptr = head_q + PTR_W'(flush_off) + PTR_W'(1);

    assign flush_acc   = (state_q == ST_RUN) && flush_valid && flush_occ && (flush_ptr != tail_q);
    assign commit      = (state_q == ST_RUN) && !empty && done_q[head_idx];
    assign alloc_ready = (state_q == ST_RUN) && !full && !flush_valid;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_idx   = tail_idx;
    assign count       = cnt;
    assign busy        = (state_q == ST_ROLLBACK);

    // Next-state and pointer update.
    always_comb begin
        state_nxt  = state_q;
        head_nxt   = head_q;
        tail_nxt   = tail_q;
        target_nxt = target_q;
        case (state_q)
            ST_RUN: begin
                if (commit) begin
                    head_nxt = head_q + PTR_W'(1);
                end
                if (alloc_fire) begin
                    tail_nxt = tail_q + PTR_W'(1);
                end
                if (flush_acc) begin
                    state_nxt  = ST_ROLLBACK;
                    target_nxt = flush_ptr;
                end
            end
            ST_ROLLBACK: begin
                tail_nxt = tail_q - PTR_W'(1);
                if (tail_nxt == target_q) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            head_q   <= '0;
            tail_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_nxt;
            head_q   <= head_nxt;
            tail_q   <= tail_nxt;
            target_q <= target_nxt;
        end
    end

    // Done bits: cleared on allocation, set by writeback to occupied slots only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
        end else begin
            if (alloc_fire) begin
                done_q[tail_idx] <= 1'b0;
            end
            if (done_valid && done_occ) begin
                done_q[done_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_idx] <= alloc_has_dest;
            arch_q[tail_idx]     <= alloc_arch_rd;
            old_preg_q[tail_idx] <= alloc_old_preg;
            new_preg_q[tail_idx] <= alloc_new_preg;
        end
    end

    // Free-list and map-restore pulses, one cycle after the commit/pop decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_w_en        <= 1'b0;
            free_dat         <= '0;
            map_restore_en   <= 1'b0;
            map_restore_arch <= '0;
            map_restore_preg <= '0;
        end else begin
            free_w_en      <= 1'b0;
            map_restore_en <= 1'b0;
            if (commit && has_dest_q[head_idx]) begin
                free_w_en <= 1'b1;
                free_dat  <= old_preg_q[head_idx];
            end
            if ((state_q == ST_ROLLBACK) && has_dest_q[pop_idx]) begin
                free_w_en        <= 1'b1;
                free_dat         <= new_preg_q[pop_idx];
                map_restore_en   <= 1'b1;
                map_restore_arch <= arch_q[pop_idx];
                map_restore_preg <= old_preg_q[pop_idx];
            end
        end
    end

endmodule

// File: tb/tb_rename_active_list.sv
// Self-checking bench for rename_active_list against a queue-based reference model.
module tb_rename_active_list;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_valid, alloc_ready, alloc_has_dest;
    logic [4:0] alloc_arch_rd;
    logic [5:0] alloc_old_preg, alloc_new_preg;
    logic [4:0] alloc_idx;
    logic       done_valid, flush_valid;
    logic [4:0] done_idx, flush_idx;
    logic       free_w_en, map_restore_en, busy;
    logic [5:0] free_dat, map_restore_preg;
    logic [4:0] map_restore_arch;
    logic [5:0] count;

    rename_active_list #(.DEPTH(32), .PREG_W(6), .AREG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_arch_rd(alloc_arch_rd),
        .alloc_old_preg(alloc_old_preg), .alloc_new_preg(alloc_new_preg),
        .alloc_idx(alloc_idx),
        .done_valid(done_valid), .done_idx(done_idx),
        .flush_valid(flush_valid), .flush_idx(flush_idx),
        .free_w_en(free_w_en), .free_dat(free_dat),
        .map_restore_en(map_restore_en), .map_restore_arch(map_restore_arch),
        .map_restore_preg(map_restore_preg),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
        $fatal(1);
    end

    // Reference model: q[0] is the oldest entry, whose slot index is m_head.
    typedef struct {
        bit       has_dest;
        bit [4:0] arch;
        bit [5:0] oldp;
        bit [5:0] newp;
        bit       done;
    } ent_t;

    ent_t     q[$];
    int       m_head, m_pop_left;
    bit       m_rb;
    bit       e_free_en, e_map_en;
    bit [5:0] e_free_dat, e_map_preg;
    bit [4:0] e_map_arch;
    int       checks, errors;

    function automatic bit m_ready();
        return !m_rb && q.size() < DEPTH && !flush_valid;
    endfunction

    function automatic logic [4:0] m_alloc_idx();
        return 5'((m_head + q.size()) % DEPTH);
    endfunction

    function automatic logic [25:0] obs_vec();
        return {free_w_en, free_w_en ? free_dat : 6'd0, map_restore_en,
                map_restore_en ? map_restore_arch : 5'd0,
                map_restore_en ? map_restore_preg : 6'd0, busy, count};
    endfunction

    function automatic logic [25:0] exp_vec();
        return {e_free_en, e_free_en ? e_free_dat : 6'd0, e_map_en,
                e_map_en ? e_map_arch : 5'd0, e_map_en ? e_map_preg : 6'd0,
                m_rb, 6'(q.size())};
    endfunction

    task automatic model_reset();
        q.delete();
        m_head = 0; m_pop_left = 0; m_rb = 0;
        e_free_en = 0; e_map_en = 0; e_free_dat = 0; e_map_arch = 0; e_map_preg = 0;
    endtask

    task automatic model_mark_done();
        int   off;
        ent_t e;
        off = (int'(done_idx) - m_head + DEPTH) % DEPTH;
        if (done_valid && off < q.size()) begin
            e = q[off]; e.done = 1; q[off] = e;
        end
    endtask

    // Apply one clock edge worth of behaviour using the current inputs.
    task automatic model_step();
        ent_t e;
        bit   do_commit, rdy;
        int   off;
        rdy = m_ready();
        e_free_en = 0; e_map_en = 0;
        if (!m_rb) begin
            do_commit = q.size() > 0 && q[0].done;
            off = (int'(flush_idx) - m_head + DEPTH) % DEPTH;
            if (flush_valid && off < q.size() && off + 1 != q.size()) begin
                m_rb = 1;
                m_pop_left = q.size() - off - 1;
            end
            model_mark_done();
            if (do_commit) begin
                e = q.pop_front();
                m_head = (m_head + 1) % DEPTH;
                if (e.has_dest) begin e_free_en = 1; e_free_dat = e.oldp; end
            end
            if (alloc_valid && rdy) begin
                e.has_dest = alloc_has_dest; e.arch = alloc_arch_rd;
                e.oldp = alloc_old_preg; e.newp = alloc_new_preg; e.done = 0;
                q.push_back(e);
            end
        end else begin
            model_mark_done();
            e = q.pop_back();
            if (e.has_dest) begin
                e_free_en = 1; e_free_dat = e.newp;
                e_map_en = 1; e_map_arch = e.arch; e_map_preg = e.oldp;
            end
            m_pop_left--;
            if (m_pop_left == 0) m_rb = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alloc_valid = 0; alloc_has_dest = 0; alloc_arch_rd = 0;
        alloc_old_preg = 0; alloc_new_preg = 0;
        done_valid = 0; done_idx = 0; flush_valid = 0; flush_idx = 0;
    endtask

    task automatic drive_alloc(input bit hd, input logic [4:0] a, input logic [5:0] o,
                               input logic [5:0] n);
        alloc_valid = 1; alloc_has_dest = hd; alloc_arch_rd = a;
        alloc_old_preg = o; alloc_new_preg = n;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs_vec() !== 26'd0 || alloc_ready !== 1'b1 || alloc_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset: got outputs %h ready %b idx %0d, required 0 ready 1 idx 0",
                     obs_vec(), alloc_ready, alloc_idx);
        end
    endtask

    task automatic test_basic();
        int got[$];
        int cyc[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(1, 5'(4 + i), 6'(1 + i), 6'(32 + i));
            #1;
            checks++;
            if (alloc_ready !== 1'b1 || alloc_idx !== 5'(i)) begin
                errors++;
                $display("FAIL basic_alloc: got ready %b idx %0d, required ready 1 idx %0d",
                         alloc_ready, alloc_idx, i);
            end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_alloc_cycle: got %h required %h", obs_vec(), exp_vec());
            end
        end
        alloc_valid = 0;
        for (int c = 0; c < 6; c++) begin
            done_valid = (c < 3);
            done_idx = 5'(c);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_commit_cycle: got %h required %h", obs_vec(), exp_vec());
            end
            if (free_w_en) begin got.push_back(int'(free_dat)); cyc.push_back(c); end
        end
        done_valid = 0;
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3
            || cyc[1] != cyc[0] + 1 || cyc[2] != cyc[1] + 1 || count !== 6'd0) begin
            errors++;
            $display("FAIL basic_frees: got %0d frees count %0d, required 1,2,3 consecutive count 0",
                     got.size(), count);
        end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive_alloc(1'($urandom), 5'($urandom), 6'($urandom), 6'($urandom));
            #1;
            checks++;
            if (alloc_ready !== m_ready() || alloc_idx !== m_alloc_idx()) begin
                errors++;
                $display("FAIL full_alloc: got ready %b idx %0d, required ready %b idx %0d",
                         alloc_ready, alloc_idx, m_ready(), m_alloc_idx());
            end
            tick();
        end
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || count !== 6'd32) begin
            errors++;
            $display("FAIL full_stall: got ready %b count %0d, required ready 0 count 32",
                     alloc_ready, count);
        end
        alloc_valid = 0; done_valid = 1; done_idx = 0;
        tick();
        done_valid = 0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || alloc_ready !== 1'b1 || alloc_idx !== 5'd0) begin
            errors++;
            $display("FAIL full_wrap: got %h ready %b idx %0d, required %h ready 1 idx 0",
                     obs_vec(), alloc_ready, alloc_idx, exp_vec());
        end
        drive_alloc(1, 5'd9, 6'd9, 6'd50);
        tick();
        alloc_valid = 0;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            done_valid = 1;
            done_idx = 5'((m_head + $urandom_range(q.size() - 1)) % DEPTH);
            tick();
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain_cycle: got %h required %h", obs_vec(), exp_vec());
            end
        end
        done_valid = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL full_drain_timeout: got %0d entries left, required 0", q.size());
        end
    endtask

    task automatic test_ooo();
        int got[$];
        int cyc[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(1, 5'(i), 6'(7 + i), 6'(40 + i));
            tick();
        end
        alloc_valid = 0;
        for (int c = 0; c < 8; c++) begin
            done_valid = (c < 3);
            done_idx = 5'(2 - c);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ooo_cycle: got %h required %h", obs_vec(), exp_vec());
            end
            if (free_w_en) begin got.push_back(int'(free_dat)); cyc.push_back(c); end
        end
        done_valid = 0;
        checks++;
        if (got.size() != 3 || got[0] != 7 || got[1] != 8 || got[2] != 9
            || cyc[0] != 3 || cyc[1] != 4 || cyc[2] != 5) begin
            errors++;
            $display("FAIL ooo_frees: got %0d frees, required 7,8,9 at cycles 3,4,5", got.size());
        end
    endtask

    task automatic test_flush();
        int busy_n;
        int rs[$];
        int fr[$];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(1, 5'(10 + i), 6'(1 + i), 6'(40 + i));
            tick();
        end
        alloc_valid = 1; flush_valid = 1; flush_idx = 1;
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_alloc: got ready %b, required 0", alloc_ready);
        end
        tick();
        alloc_valid = 0; flush_valid = 0;
        busy_n = busy ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL flush_cycle: got %h required %h", obs_vec(), exp_vec());
            end
            if (busy) busy_n++;
            if (map_restore_en) rs.push_back(int'(map_restore_arch) * 100 + int'(map_restore_preg));
            if (free_w_en) fr.push_back(int'(free_dat));
        end
        checks++;
        if (busy_n != 3 || rs.size() != 3 || fr.size() != 3 || count !== 6'd2
            || rs[0] != 1405 || rs[1] != 1304 || rs[2] != 1203
            || fr[0] != 44 || fr[1] != 43 || fr[2] != 42) begin
            errors++;
            $display("FAIL flush_rollback: got busy %0d restores %0d frees %0d count %0d, required 3 3 3 2",
                     busy_n, rs.size(), fr.size(), count);
        end
    endtask

    task automatic test_flush_noop();
        bit seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(1, 5'(i), 6'(i), 6'(20 + i));
            tick();
        end
        alloc_valid = 0;
        for (int k = 0; k < 2; k++) begin
            seen = 0;
            flush_valid = 1;
            flush_idx = (k == 0) ? 5'd3 : 5'd9;
            tick();
            flush_valid = 0;
            for (int c = 0; c < 3; c++) begin
                if (busy || free_w_en || map_restore_en) seen = 1;
                tick();
            end
            checks++;
            if (seen || obs_vec() !== exp_vec() || count !== 6'd4) begin
                errors++;
                $display("FAIL flush_noop_%0d: got activity %b count %0d, required none count 4",
                         k, seen, count);
            end
        end
    endtask

    task automatic test_commit_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(1, 5'(i), 6'(30 + i), 6'(50 + i));
            tick();
        end
        alloc_valid = 0; done_valid = 1; done_idx = 0;
        tick();
        done_valid = 0; flush_valid = 1; flush_idx = 0;
        tick();
        flush_valid = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL commit_flush_cycle: got %h required %h", obs_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (count !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_flush_end: got count %0d busy %b, required 0 0", count, busy);
        end
    endtask

    task automatic test_reset_rollback();
        bit seen;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(1, 5'(i), 6'(i), 6'(30 + i));
            tick();
        end
        alloc_valid = 0; flush_valid = 1; flush_idx = 0;
        tick();
        flush_valid = 0;
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs_vec() !== 26'd0 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rollback: got %h ready %b, required 0 ready 1", obs_vec(), alloc_ready);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (free_w_en || map_restore_en || busy || count !== 6'd0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_rollback_after: got activity after release, required none");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            alloc_valid = ((c % 500) < 250) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            alloc_has_dest = 1'($urandom_range(3) != 0);
            alloc_arch_rd = 5'($urandom); alloc_old_preg = 6'($urandom); alloc_new_preg = 6'($urandom);
            done_valid = 1'($urandom);
            done_idx = 5'((m_head + $urandom_range(q.size() + 2)) % DEPTH);
            flush_valid = ($urandom_range(24) == 0);
            flush_idx = 5'((m_head + $urandom_range(q.size() + 1)) % DEPTH);
            #1;
            checks++;
            if (alloc_ready !== m_ready() || alloc_idx !== m_alloc_idx()) begin
                errors++;
                $display("FAIL random_ready: got ready %b idx %0d, required ready %b idx %0d",
                         alloc_ready, alloc_idx, m_ready(), m_alloc_idx());
            end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h required %h", c, obs_vec(), exp_vec());
            end
        end
        set_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_idle();
        test_reset();
        test_basic();
        test_full();
        test_ooo();
        test_flush();
        test_flush_noop();
        test_commit_flush();
        test_reset_rollback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_active_list.md
# rename_active_list

In-order active list for the register-rename stage; it is the producer side of the physical-register free list. It records every renamed instruction's {arch_rd, old_preg, new_preg}. At in-order commit it returns old_preg to the free list. On a flush it walks the squashed entries youngest-first, restoring the rename map and returning new_preg to the free list. It sits between rename/dispatch, writeback (done marking), the free-list FIFO and the rename map table.

## Interface
- DEPTH, 32: entries, power of two; IDX_W = $clog2(DEPTH)
- PREG_W, 6: physical register tag width
- AREG_W, 5: architectural register index width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  rename presents an instruction
- alloc_ready  out  1  entry accepted this cycle when alloc_valid & alloc_ready
- alloc_has_dest  in  1  instruction writes a register
- alloc_arch_rd  in  AREG_W  architectural destination
- alloc_old_preg  in  PREG_W  previous mapping of arch_rd
- alloc_new_preg  in  PREG_W  newly allocated physical register
- alloc_idx  out  IDX_W  index given to the presented instruction (tail)
- done_valid  in  1  writeback completion
- done_idx  in  IDX_W  completed entry
- flush_valid  in  1  squash all entries younger than flush_idx
- flush_idx  in  IDX_W  youngest surviving entry
- free_w_en  out  1  push to free list
- free_dat  out  PREG_W  register pushed
- map_restore_en  out  1  rename map write
- map_restore_arch  out  AREG_W  map index
- map_restore_preg  out  PREG_W  restored mapping
- busy  out  1  rollback in progress
- count  out  IDX_W+1  occupied entries

## Operation
- Storage per entry: has_dest, arch_rd, old_preg, new_preg, done.
- Pointers head and tail are IDX_W+1 bits; the extra bit is the wrap bit. count = tail - head (mod 2^(IDX_W+1)).
- empty: count == 0. full: count == DEPTH.
- States RUN and ROLLBACK. Reset state is RUN.
- alloc_ready = (state==RUN) & !full & !flush_valid (combinational). An accepted alloc writes the entry at tail with done=0 and increments tail.
- done_valid sets done at done_idx only if that slot is occupied; otherwise it is ignored. A done to an already-done entry has no effect.
- Commit happens in RUN only, at most one entry per cycle: when !empty and head entry done, head increments. If has_dest, the next cycle has free_w_en=1 and free_dat=old_preg. Entries without a destination commit silently.
- Flush in RUN with flush_idx occupied:
  - Set target = pointer of flush_idx + 1.
  - If target == tail, nothing is squashed and the block stays in RUN.
  - Otherwise the block enters ROLLBACK.
- Flush is ignored when flush_idx is unoccupied or when the block is in ROLLBACK.
- ROLLBACK, each cycle:
  - Decrement tail and pop the entry at the new tail.
  - If has_dest, the next cycle has map_restore_en=1 with arch_rd→old_preg, and free_w_en=1 with free_dat=new_preg.
  - When tail == target, return to RUN.
  - Because rollback runs youngest-first, the map ends at the oldest surviving mapping.
- Commit is frozen during ROLLBACK; done marking continues.
- Commit and flush in the same cycle: the head commit proceeds. Target is unaffected, even when flush_idx is the committing head.
- Wrap-around: all index arithmetic is mod DEPTH on the low bits. The wrap bit only distinguishes full from empty.

## Timing
- Reset values: free_w_en=0, free_dat=0, map_restore_en=0, map_restore_arch=0, map_restore_preg=0, busy=0, count=0. Head and tail are 0, all done bits are 0, and alloc_ready=1 after reset.
- Reset asserted mid-rollback abandons the rollback. No further free/restore pulses are issued.
- alloc_idx and alloc_ready are combinational from the current state. An accepted entry becomes visible in count the next cycle.
- A done marked at edge N allows that entry to commit at edge N+1 at the earliest. The free_w_en pulse appears in cycle N+2.
- The free and restore outputs are registered, with 1-cycle latency from the commit or pop decision.
- busy goes high the cycle after the accepted flush and stays high for exactly k cycles when k entries are squashed. Pulses occur on the k pop cycles shifted by one, so the last pulse coincides with the first cycle of busy=0.
- Throughput:
  - One alloc and one commit per cycle, concurrently.
  - Rollback runs at 1 entry per cycle.
  - Alloc is blocked from the flush cycle through the last ROLLBACK cycle.

## Test plan
- Reset, then alloc 3 entries with new_preg 32,33,34 and old_preg 1,2,3; mark done 0,1,2 → free_dat 1,2,3 on consecutive cycles, then count=0.
- Fill to 32 entries → alloc_ready=0 at count=32. Commit one → alloc_ready=1, and the next alloc_idx wraps to 0.
- Out-of-order done: mark 2, then 1, then 0 → no commit until idx0 is done, then 3 consecutive commits.
- Alloc idx0..4 (all has_dest), flush_idx=1 → busy high 3 cycles. Restores pop idx4,3,2 (arch→old_preg), free_dat = new_preg of 4,3,2, and final count=2.
- Flush with flush_idx = youngest entry → no busy, no pulses. Flush to an unoccupied idx → ignored.
- Assert rst_n low during ROLLBACK after 1 pop → all outputs are 0 immediately, count=0, and no further pulses after release.
